// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access sequencer.
// State encoding, word offset and parameter range checks.
package mem_access_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        WRITE,
        DONE_W,
        READ,
        WAIT,
        CAPTURE,
        DONE_R
    } state_t;

    localparam int WORD_OFS = 2;
    localparam int LAT_MIN  = 1;
    localparam int LAT_MAX  = 7;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    // Misaligned word access, or any byte address past the BRAM capacity.
    function automatic logic addr_bad(
        input logic [31:0] a,
        input int          aw
    );
        logic mis;
        logic oor;
        mis = (a[WORD_OFS-1:0] != '0);
        oor = ((a >> (aw + WORD_OFS)) != 32'd0);
        return mis | oor;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lat_counter.sv
// Read latency counter for the memory access sequencer.
// 3-bit loadable down-counter that stops at zero.
module lat_counter (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt;

    // Load wins over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign zero = (cnt == 3'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle sequencer between core datapath and single-port BRAM.
// Validates each request, drives BRAM timing and registers read data.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 15,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
        $error("mem_access_ctrl: RD_LAT must be within 1..7");
    end

    state_t state;
    logic   idle_like;
    logic   accept;
    logic   bad;
    logic   is_wr;
    logic   is_rd;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    // Requests are only taken in states where busy is low.
    assign idle_like = (state == IDLE) ||
                       (state == DONE_W) ||
                       (state == DONE_R);
    assign accept    = req && idle_like;
    assign bad       = addr_bad(addr, MEM_AW);
    assign is_wr     = !bad && we;
    assign is_rd     = !bad && !we;
    assign cnt_load  = accept && is_rd;
    assign cnt_dec   = (state == READ) || (state == WAIT);

    lat_counter u_lat (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (3'(RD_LAT - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Sequencer with all outputs registered from the next-state decision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rvalid   <= 1'b0;
            err      <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            rdata    <= '0;
        end else begin
            done   <= 1'b0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            unique case (state)
                IDLE, DONE_W, DONE_R: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (accept) begin
                        busy     <= 1'b1;
                        mem_addr <= addr[WORD_OFS +: MEM_AW];
                        mem_din  <= wdata;
                        unique case (1'b1)
                            bad: begin
                                state <= ERR;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end
                            is_wr: begin
                                state  <= WRITE;
                                mem_en <= 1'b1;
                                mem_we <= 1'b1;
                            end
                            is_rd: begin
                                state  <= READ;
                                mem_en <= 1'b1;
                            end
                        endcase
                    end
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                WRITE: begin
                    state <= DONE_W;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                READ, WAIT: begin
                    state <= cnt_zero ? CAPTURE : WAIT;
                end
                CAPTURE: begin
                    rdata  <= mem_dout;
                    state  <= DONE_R;
                    done   <= 1'b1;
                    rvalid <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multicycle memory access sequencer between the core datapath and a synchronous block RAM (instruction + data, single port).
- Turns a one-cycle request (iord/memwrite strobes resolved by the datapath) into BRAM enable/write timing, waits a parameterised read latency, and registers read data with a done strobe.
- Checks alignment and range; flags bad accesses instead of touching memory.

Parameters:
- DATA_W, 32, data width in bits.
- MEM_AW, 15, BRAM word-address width; capacity is 2^MEM_AW words.
- RD_LAT, 2, BRAM read latency in cycles from the enable cycle to valid mem_dout; legal range 1..7.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, active-low, asynchronous.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  32  byte address.
- wdata  in  DATA_W  write data.
- busy  out  1  access in progress; req is ignored while high.
- done  out  1  one-cycle pulse when an access finishes, including error terminations.
- rvalid  out  1  one-cycle pulse with done for a successful read.
- rdata  out  DATA_W  registered read data; held until the next successful read.
- err  out  1  one-cycle pulse with done: misaligned or out-of-range access.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  MEM_AW  BRAM word address, addr[MEM_AW+1:2].
- mem_din  out  DATA_W  BRAM write data.
- mem_dout  in  DATA_W  BRAM read data.

Behaviour:
- Reset is asynchronous, active-low, on clk/rstn. Asserting it puts the FSM in IDLE and clears busy, done, rvalid, err, mem_en, mem_we, mem_addr, mem_din, rdata and the latency counter immediately. An in-flight access is abandoned, and a read pending at reset never produces rvalid.
- Cycle 0: req=1 while in IDLE. At edge 1 the block latches addr, we and wdata.
- States: IDLE, CHECK-free design; validity is evaluated combinationally at acceptance.
  - IDLE: busy=0. On req, the next state is ERR, WRITE or READ.
  - ERR: entered if addr[1:0]!=0 or addr[31:MEM_AW+2]!=0. done=err=1, busy=1 for one cycle, then IDLE. No mem_en is issued.
  - WRITE: mem_en=mem_we=1 and mem_din=latched wdata for exactly one cycle (cycle 1). Next is DONE_W.
  - DONE_W: done=1, busy=0, then IDLE. A new req is accepted in this cycle.
  - READ: mem_en=1, mem_we=0 in cycle 1. The counter loads RD_LAT-1. Next is WAIT, or CAPTURE if RD_LAT=1.
  - WAIT: mem_en=0. The counter decrements each cycle and moves to CAPTURE when it reaches 0.
  - CAPTURE: this is cycle 1+RD_LAT. mem_dout is sampled into rdata at edge 2+RD_LAT.
  - DONE_R: cycle 2+RD_LAT. done=rvalid=1, busy=0, rdata valid. A new req is accepted here.
- Busy windows: busy=1 from cycle 1 through cycle 1+RD_LAT for reads, cycle 1 for writes, and cycle 1 for errors.
- Read latency: req to rvalid is 2+RD_LAT cycles, which is 4 with the default.
- mem_addr is driven from the latched address and is stable for the whole access.
- A req while busy=1 is dropped with no side effects. A req held high across done starts a new access.
- rdata is not modified by writes or errors.
- done, rvalid and err never assert in the same cycle as reset release unless an access has completed.

Decomposition:
- Shared package mem_access_pkg holds:
  - the state enum (IDLE, ERR, WRITE, DONE_W, READ, WAIT, CAPTURE, DONE_R);
  - the localparam WORD_OFS=2;
  - the RD_LAT range check used in an elaboration-time assertion.
- One sub-module, lat_counter: a 3-bit loadable down-counter with a zero flag, async active-low reset.

Test Plan:
- Read, RD_LAT=2: preload word 0x0000_0010 = 0xDEADBEEF, req=1 we=0 addr=0x40 in cycle 0.
  → mem_en=1 only in cycle 1, mem_addr=0x10, busy cycles 1–3, rvalid/done in cycle 4, rdata=0xDEADBEEF held afterwards.
- Write then read-back: write 0x12345678 to addr 0x100, then read addr 0x100.
  → mem_we pulse in cycle 1 with mem_addr=0x40, done in cycle 2, and the read returns 0x12345678 with rvalid 4 cycles after its req.
- Misaligned: req to addr 0x42.
  → err=done=1 in cycle 1, mem_en never high, rdata unchanged.
- Out of range (MEM_AW=15): req to addr 0x0002_0000.
  → err pulse, no BRAM access.
- Req while busy: second req at cycle 2 of a read.
  → ignored, exactly one mem_en pulse. A req in the DONE_R cycle is accepted, giving back-to-back reads with rvalid at cycles 4 and 8.
- Reset mid-read: deassert rstn in cycle 2 of a read.
  → all outputs 0 immediately, no rvalid after release, and the next read completes normally with RD_LAT=1 and RD_LAT=7 variants.
